// File: rtl/adc_acq_ctrl_pkg.sv
// Shared definitions for the ADC acquisition sequencer: state encoding,
// default widths and a small state-decode helper.
package adc_acq_ctrl_pkg;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DECIM_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } acq_state_t;

   // States in which the decimator runs and samples are written.
   function automatic logic acq_active(input acq_state_t s);
      return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/adc_acq_ctrl_decim.sv
// Decimation down-counter: emits one strobe every reload+1 enabled cycles.
// The strobe is decoded from the counter register and the registered enable.
module acq_decim #(
   parameter int DECIM_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               load,
   input  logic               en,
   input  logic [DECIM_W-1:0] reload,
   output logic               strobe
);

   logic [DECIM_W-1:0] cnt_reg;

   // Load at run start, reload on every strobe, otherwise count down while enabled.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= reload;
      end else if (en) begin
         if (cnt_reg == '0)
            cnt_reg <= reload;
         else
            cnt_reg <= cnt_reg - DECIM_W'(1);
      end
   end

   assign strobe = en && (cnt_reg == '0);

endmodule

// File: rtl/adc_acq_ctrl.sv
// ADC acquisition sequencer: pre-trigger fill, armed wait with one-cycle
// trigger blanking, post-trigger capture into a circular sample buffer.
module adc_acq_ctrl
   import adc_acq_ctrl_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DECIM_W = DEF_DECIM_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               ABORT,
   input  logic               FORCE,
   input  logic [DECIM_W-1:0] DECIM,
   input  logic [ADDR_W-1:0]  PRETRIG,
   input  logic [ADDR_W-1:0]  POSTTRIG,
   input  logic               trig_in,
   output logic               trg_ev_en,
   output logic               clk_en,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [ADDR_W-1:0]  trig_addr,
   output logic               busy,
   output logic               done
);

   acq_state_t        state_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [ADDR_W-1:0] trig_addr_reg;
   logic [ADDR_W-1:0] pre_cnt_reg;
   logic [ADDR_W-1:0] post_cnt_reg;
   logic              blank_reg;     // first ARMED cycle: trigger block still clearing
   logic              strobe;
   logic              active;
   logic              start_load;
   logic [ADDR_W-1:0] addr_inc;

   assign active     = acq_active(state_reg);
   assign start_load = START && !ABORT && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign addr_inc   = wr_addr_reg + ADDR_W'(1);   // wraps naturally at all-ones

   acq_decim #(
      .DECIM_W (DECIM_W)
   ) u_decim (
      .CLK    (CLK),
      .RST    (RST),
      .load   (start_load),
      .en     (active),
      .reload (DECIM),
      .strobe (strobe)
   );

   // Sequencer FSM together with write address, phase counters and trigger capture.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg     <= ST_IDLE;
         wr_addr_reg   <= '0;
         trig_addr_reg <= '0;
         pre_cnt_reg   <= '0;
         post_cnt_reg  <= '0;
         blank_reg     <= 1'b0;
      end else if (ABORT) begin
         state_reg <= ST_IDLE;
         blank_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               blank_reg <= 1'b0;
               if (START) begin
                  wr_addr_reg <= '0;
                  pre_cnt_reg <= PRETRIG;
                  if (PRETRIG != '0) begin
                     state_reg <= ST_PRE;
                  end else begin
                     state_reg <= ST_ARMED;
                     blank_reg <= 1'b1;
                  end
               end
            end
            ST_PRE: begin
               if (strobe) begin
                  wr_addr_reg <= addr_inc;
                  pre_cnt_reg <= pre_cnt_reg - ADDR_W'(1);
                  if (pre_cnt_reg == ADDR_W'(1)) begin
                     state_reg <= ST_ARMED;
                     blank_reg <= 1'b1;
                  end
               end
            end
            ST_ARMED: begin
               blank_reg <= 1'b0;
               if (strobe)
                  wr_addr_reg <= addr_inc;
               if (!blank_reg && (trig_in || FORCE)) begin
                  // A coincident strobe belongs to ARMED, so point past it.
                  trig_addr_reg <= strobe ? addr_inc : wr_addr_reg;
                  post_cnt_reg  <= POSTTRIG;
                  state_reg     <= (POSTTRIG != '0) ? ST_POST : ST_DONE;
               end
            end
            ST_POST: begin
               if (strobe) begin
                  wr_addr_reg  <= addr_inc;
                  post_cnt_reg <= post_cnt_reg - ADDR_W'(1);
                  if (post_cnt_reg == ADDR_W'(1))
                     state_reg <= ST_DONE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               blank_reg <= 1'b0;
            end
         endcase
      end
   end

   assign trg_ev_en = (state_reg == ST_ARMED);
   assign clk_en    = strobe;
   assign wr_en     = strobe;
   assign wr_addr   = wr_addr_reg;
   assign trig_addr = trig_addr_reg;
   assign busy      = active;
   assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Self-checking bench for adc_acq_ctrl. Expected behaviour of each run is
// derived arithmetically from the run parameters (strobe cadence, phase
// boundaries, sample counts) rather than by stepping a state machine.
module tb_adc_acq_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          START = 1'b0;
   logic          ABORT = 1'b0;
   logic          FORCE = 1'b0;
   logic [DW-1:0] DECIM = '0;
   logic [AW-1:0] PRETRIG = '0;
   logic [AW-1:0] POSTTRIG = '0;
   logic          trig_in = 1'b0;
   logic          trg_ev_en, clk_en, wr_en, busy, done;
   logic [AW-1:0] wr_addr, trig_addr;

   int checks = 0;
   int failures = 0;

   adc_acq_ctrl #(.ADDR_W(AW), .DECIM_W(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .ABORT     (ABORT),
      .FORCE     (FORCE),
      .DECIM     (DECIM),
      .PRETRIG   (PRETRIG),
      .POSTTRIG  (POSTTRIG),
      .trig_in   (trig_in),
      .trg_ev_en (trg_ev_en),
      .clk_en    (clk_en),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .trig_addr (trig_addr),
      .busy      (busy),
      .done      (done)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle_outputs(input string name, input logic [AW-1:0] exp_wa,
                                     input logic [AW-1:0] exp_ta, input logic exp_done);
      checks++;
      if ({trg_ev_en, clk_en, wr_en, busy, done} !== {4'b0000, exp_done}) begin
         failures++;
         $display("FAIL %s flags got ev=%b ce=%b we=%b busy=%b done=%b exp all 0 done=%b",
                  name, trg_ev_en, clk_en, wr_en, busy, done, exp_done);
      end
      checks++;
      if (wr_addr !== exp_wa) begin
         failures++;
         $display("FAIL %s wr_addr got=%0d exp=%0d", name, wr_addr, exp_wa);
      end
      checks++;
      if (trig_addr !== exp_ta) begin
         failures++;
         $display("FAIL %s trig_addr got=%0d exp=%0d", name, trig_addr, exp_ta);
      end
   endtask

   // One complete acquisition. Cycle c=0 is the first cycle after the START edge.
   // Trigger source goes high at armed_start+trig_rel and stays high.
   task automatic run_acq(input string name, input int d, input int p, input int q,
                          input int trig_rel, input bit use_force, input bit noise,
                          output int trig_addr_exp);
      int armed_start, t_det, a_cnt, total, done_cycle, wa;
      logic exp_busy, exp_arm, exp_str;
      bit fire;
      armed_start = p * (d + 1);
      t_det       = armed_start + ((trig_rel < 1) ? 1 : trig_rel);
      a_cnt       = (t_det - armed_start + 1) / (d + 1);
      total       = p + a_cnt + q;
      done_cycle  = (q == 0) ? t_det + 1 : total * (d + 1);
      trig_addr_exp = (p + a_cnt) % (1 << AW);

      DECIM = DW'(d); PRETRIG = AW'(p); POSTTRIG = AW'(q);
      START = 1'b1; trig_in = 1'b0; FORCE = 1'b0;
      for (int c = 0; c <= done_cycle + 2; c++) begin
         tick();
         START = 1'b0;
         fire = (c >= armed_start + trig_rel);
         if (c < armed_start) begin
            trig_in = noise ? 1'($urandom) : 1'b0;
            FORCE   = noise ? 1'($urandom) : 1'b0;
            if (noise) PRETRIG = AW'($urandom);
         end else if (c <= t_det) begin
            trig_in = !use_force && fire;
            FORCE   = use_force && fire;
         end else begin
            trig_in = !use_force;
            FORCE   = noise ? 1'($urandom) : 1'b0;
         end

         exp_busy = (c < done_cycle);
         exp_arm  = (c >= armed_start) && (c <= t_det);
         exp_str  = exp_busy && ((c % (d + 1)) == d);
         wa       = c / (d + 1);
         if (wa > total) wa = total;

         checks++;
         if (busy !== exp_busy || done !== !exp_busy) begin
            failures++;
            $display("FAIL %s c=%0d busy/done got=%b%b exp=%b%b", name, c, busy, done,
                     exp_busy, !exp_busy);
         end
         checks++;
         if (trg_ev_en !== exp_arm) begin
            failures++;
            $display("FAIL %s c=%0d trg_ev_en got=%b exp=%b", name, c, trg_ev_en, exp_arm);
         end
         checks++;
         if (clk_en !== exp_str || wr_en !== exp_str) begin
            failures++;
            $display("FAIL %s c=%0d clk_en/wr_en got=%b%b exp=%b", name, c, clk_en, wr_en, exp_str);
         end
         checks++;
         if (wr_addr !== AW'(wa % (1 << AW))) begin
            failures++;
            $display("FAIL %s c=%0d wr_addr got=%0d exp=%0d", name, c, wr_addr, wa % (1 << AW));
         end
         if (c > t_det) begin
            checks++;
            if (trig_addr !== AW'(trig_addr_exp)) begin
               failures++;
               $display("FAIL %s c=%0d trig_addr got=%0d exp=%0d", name, c, trig_addr, trig_addr_exp);
            end
         end
      end
      trig_in = 1'b0; FORCE = 1'b0;
      $display("run %s d=%0d p=%0d q=%0d trig_rel=%0d force=%0d trig_addr=%0d done_cycle=%0d",
               name, d, p, q, trig_rel, use_force, trig_addr, done_cycle);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset", '0, '0, 1'b0);
      RST = 1'b1;
      tick();
      check_idle_outputs("reset_release", '0, '0, 1'b0);
      $display("test_reset done");
   endtask

   task automatic test_basic();
      int ta;
      run_acq("basic", 0, 4, 3, 5, 1'b0, 1'b0, ta);
      checks++;
      if (trig_addr !== AW'(10) || wr_addr !== AW'(13)) begin
         failures++;
         $display("FAIL basic_const trig_addr=%0d wr_addr=%0d exp 10 13", trig_addr, wr_addr);
      end
   endtask

   task automatic test_decim_force();
      int ta;
      run_acq("decim_force", 2, 2, 1, 2, 1'b1, 1'b0, ta);
   endtask

   task automatic test_wrap();
      int ta;
      run_acq("wrap", 0, 15, 2, 4, 1'b0, 1'b0, ta);
      checks++;
      if (trig_addr !== AW'(4)) begin
         failures++;
         $display("FAIL wrap_const trig_addr got=%0d exp=4", trig_addr);
      end
   endtask

   task automatic test_blanking();
      int ta;
      run_acq("blank", 1, 3, 2, 0, 1'b0, 1'b0, ta);
      run_acq("blank_zero", 0, 0, 0, 0, 1'b1, 1'b0, ta);
   endtask

   task automatic test_abort();
      DECIM = '0; PRETRIG = AW'(2); POSTTRIG = AW'(5);
      START = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         tick();
         START   = 1'b0;
         trig_in = (c >= 3);
      end
      ABORT = 1'b1; START = 1'b1;
      tick();
      ABORT = 1'b0; START = 1'b0;
      check_idle_outputs("abort", AW'(5), AW'(4), 1'b0);
      repeat (2) tick();
      check_idle_outputs("abort_hold", AW'(5), AW'(4), 1'b0);
      trig_in = 1'b0;
      $display("test_abort wr_addr=%0d trig_addr=%0d", wr_addr, trig_addr);
   endtask

   task automatic test_reset_mid();
      DECIM = DW'(1); PRETRIG = AW'(1); POSTTRIG = AW'(3);
      START = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         tick();
         START = 1'b0;
      end
      checks++;
      if (trg_ev_en !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_armed trg_ev_en got=%b exp=1", trg_ev_en);
      end
      RST = 1'b0;
      tick();
      check_idle_outputs("reset_mid", '0, '0, 1'b0);
      RST = 1'b1;
      tick();
      check_idle_outputs("reset_mid_after", '0, '0, 1'b0);
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int ta;
      for (int i = 0; i < 14; i++) begin
         run_acq($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
                 1'($urandom), 1'b1, ta);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decim_force();
      test_wrap();
      test_blanking();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
